// File: rtl/timestamped_stream_checker_if.sv
// Model/reference stream bundle for the timestamped stream checker.
// master drives tokens and reference transitions; slave returns readies.
interface timestamped_stream_checker_if #(
  parameter int DATA_WIDTH = 1
);
  logic                  model_valid;
  logic                  model_ready;
  logic [DATA_WIDTH-1:0] model_data;
  logic                  ref_valid;
  logic                  ref_ready;
  logic [DATA_WIDTH-1:0] ref_data;
  logic [63:0]           ref_time;

  modport master (
    output model_valid, model_data,
    output ref_valid, ref_data, ref_time,
    input  model_ready, ref_ready
  );

  modport slave (
    input  model_valid, model_data,
    input  ref_valid, ref_data, ref_time,
    output model_ready, ref_ready
  );
endinterface

// File: rtl/timestamped_stream_checker.sv
// Compares a per-cycle model stream against timestamped reference
// transitions; counts matches/mismatches and latches the first mismatch.
module timestamped_stream_checker #(
  parameter int          DATA_WIDTH = 1,
  parameter logic [63:0] PERIOD_PS  = 64'd1000
) (
  input  logic                  clock,
  input  logic                  reset,
  timestamped_stream_checker_if.slave bus,
  output logic                  error,
  output logic [31:0]           match_count,
  output logic [31:0]           mismatch_count,
  output logic [1:0]            err_kind,
  output logic [63:0]           err_model_time,
  output logic [63:0]           err_ref_time,
  output logic [DATA_WIDTH-1:0] err_model_data,
  output logic [DATA_WIDTH-1:0] err_ref_data
);

  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

  logic [63:0]           model_time;
  logic [DATA_WIDTH-1:0] prev_data;
  logic                  first;
  logic [31:0]           match_cnt;
  logic [31:0]           mismatch_cnt;

  logic       is_edge;
  logic       late_ref;
  logic       model_fire;
  logic       ref_fire;
  logic       cmp_edge;
  logic       unexpected;
  logic       hit;
  logic       miss;
  logic [1:0] kind;

  assign is_edge  = first | (bus.model_data != prev_data);
  assign late_ref = bus.ref_valid & (bus.ref_time <= model_time);

  always_comb begin
    bus.model_ready = 1'b0;
    bus.ref_ready   = 1'b0;
    if (!reset && bus.model_valid) begin
      unique case (1'b1)
        is_edge: begin
          bus.model_ready = bus.ref_valid;
          bus.ref_ready   = bus.ref_valid;
        end
        !is_edge && late_ref: bus.ref_ready = 1'b1;
        default: bus.model_ready = 1'b1;
      endcase
    end
  end

  assign model_fire = bus.model_valid & bus.model_ready;
  assign ref_fire   = bus.ref_valid & bus.ref_ready;
  assign cmp_edge   = model_fire & ref_fire;
  // A reference pop without a model pop is a transition the model never made
  assign unexpected = ref_fire & ~model_fire;

  always_comb begin
    kind = 2'd0;
    if (unexpected)
      kind = 2'd3;
    else if (bus.ref_data != bus.model_data)
      kind = 2'd2;
    else if (bus.ref_time != model_time)
      kind = 2'd1;
  end

  assign hit  = cmp_edge & (kind == 2'd0);
  assign miss = unexpected | (cmp_edge & (kind != 2'd0));

  always_ff @(posedge clock) begin
    if (reset) begin
      model_time     <= '0;
      prev_data      <= '0;
      first          <= 1'b1;
      match_cnt      <= '0;
      mismatch_cnt   <= '0;
      err_kind       <= '0;
      err_model_time <= '0;
      err_ref_time   <= '0;
      err_model_data <= '0;
      err_ref_data   <= '0;
    end else begin
      if (model_fire) begin
        model_time <= model_time + PERIOD_PS;
        prev_data  <= bus.model_data;
        first      <= 1'b0;
      end
      if (hit && match_cnt != CNT_MAX)
        match_cnt <= match_cnt + 32'd1;
      if (miss) begin
        if (mismatch_cnt != CNT_MAX)
          mismatch_cnt <= mismatch_cnt + 32'd1;
        // Counter saturates, so zero means no mismatch seen since reset
        if (mismatch_cnt == '0) begin
          err_kind       <= kind;
          err_model_time <= model_time;
          err_ref_time   <= bus.ref_time;
          err_model_data <= bus.model_data;
          err_ref_data   <= bus.ref_data;
        end
      end
    end
  end

  assign match_count    = match_cnt;
  assign mismatch_count = mismatch_cnt;
  assign error          = (mismatch_cnt != '0);

endmodule

// File: tb/tb_timestamped_stream_checker.sv
// Directed, table-driven bench for timestamped_stream_checker.
// Each vector is one cycle of inputs plus expected readies and counts.
module tb_timestamped_stream_checker;

  logic        clock;
  logic        reset;
  logic        error;
  logic [31:0] match_count;
  logic [31:0] mismatch_count;
  logic [1:0]  err_kind;
  logic [63:0] err_model_time;
  logic [63:0] err_ref_time;
  logic [0:0]  err_model_data;
  logic [0:0]  err_ref_data;

  int checks = 0;
  int errors = 0;

  timestamped_stream_checker_if #(.DATA_WIDTH(1)) bus ();

  timestamped_stream_checker #(
    .DATA_WIDTH(1),
    .PERIOD_PS (64'd1000)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .bus           (bus),
    .error         (error),
    .match_count   (match_count),
    .mismatch_count(mismatch_count),
    .err_kind      (err_kind),
    .err_model_time(err_model_time),
    .err_ref_time  (err_ref_time),
    .err_model_data(err_model_data),
    .err_ref_data  (err_ref_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        rst;
    logic        mv;
    logic        md;
    logic        rv;
    logic        rd;
    logic [63:0] rt;
    logic        mr;
    logic        rr;
    logic [31:0] mc;
    logic [31:0] xc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(
    logic rst, logic mv, logic md, logic rv, logic rd,
    logic [63:0] rt, logic mr, logic rr,
    logic [31:0] mc, logic [31:0] xc);
    vec_t t;
    t.rst = rst; t.mv = mv; t.md = md;
    t.rv = rv; t.rd = rd; t.rt = rt;
    t.mr = mr; t.rr = rr; t.mc = mc; t.xc = xc;
    return t;
  endfunction

  task automatic check(input string name,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic apply(input vec_t t);
    reset           = t.rst;
    bus.model_valid = t.mv;
    bus.model_data  = t.md;
    bus.ref_valid   = t.rv;
    bus.ref_data    = t.rd;
    bus.ref_time    = t.rt;
    #1;
    check("model_ready", 64'(bus.model_ready), 64'(t.mr));
    check("ref_ready", 64'(bus.ref_ready), 64'(t.rr));
    @(negedge clock);
    check("match_count", 64'(match_count), 64'(t.mc));
    check("mismatch_count", 64'(mismatch_count), 64'(t.xc));
    check("error", 64'(error), 64'(t.xc != 0));
  endtask

  task automatic run(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) apply(vecs[i]);
  endtask

  initial begin
    reset           = 1'b1;
    bus.model_valid = 1'b0;
    bus.model_data  = 1'b0;
    bus.ref_valid   = 1'b0;
    bus.ref_data    = 1'b0;
    bus.ref_time    = '0;

    // A: clean match run, valids high during reset
    vecs.push_back(v(1, 1, 1, 1, 1,    0, 0, 0, 0, 0));
    vecs.push_back(v(0, 1, 0, 1, 0,    0, 1, 1, 1, 0));
    vecs.push_back(v(0, 1, 0, 1, 1, 2000, 1, 0, 1, 0));
    vecs.push_back(v(0, 1, 1, 1, 1, 2000, 1, 1, 2, 0));
    vecs.push_back(v(0, 1, 1, 1, 0, 4000, 1, 0, 2, 0));
    vecs.push_back(v(0, 1, 0, 1, 0, 4000, 1, 1, 3, 0));
    vecs.push_back(v(0, 0, 0, 0, 0,    0, 0, 0, 3, 0));
    // B: time mismatch on second edge (idx 7..12)
    vecs.push_back(v(1, 0, 0, 0, 0,    0, 0, 0, 0, 0));
    vecs.push_back(v(0, 1, 0, 1, 0,    0, 1, 1, 1, 0));
    vecs.push_back(v(0, 1, 0, 1, 1, 2500, 1, 0, 1, 0));
    vecs.push_back(v(0, 1, 1, 1, 1, 2500, 1, 1, 1, 1));
    vecs.push_back(v(0, 1, 1, 1, 0, 4000, 1, 0, 1, 1));
    vecs.push_back(v(0, 1, 0, 1, 0, 4000, 1, 1, 2, 1));
    // C: unexpected reference transition (idx 13..17)
    vecs.push_back(v(1, 0, 0, 0, 0,    0, 0, 0, 0, 0));
    vecs.push_back(v(0, 1, 0, 1, 0,    0, 1, 1, 1, 0));
    vecs.push_back(v(0, 1, 0, 1, 1, 1000, 0, 1, 1, 1));
    vecs.push_back(v(0, 1, 0, 0, 0,    0, 1, 0, 1, 1));
    vecs.push_back(v(0, 1, 0, 0, 0,    0, 1, 0, 1, 1));
    // D: three mismatches then reset pulse (idx 18..22)
    vecs.push_back(v(1, 0, 0, 0, 0,    0, 0, 0, 0, 0));
    vecs.push_back(v(0, 1, 1, 1, 1,    5, 1, 1, 0, 1));
    vecs.push_back(v(0, 1, 0, 1, 0,    7, 1, 1, 0, 2));
    vecs.push_back(v(0, 1, 1, 1, 1,    9, 1, 1, 0, 3));
    vecs.push_back(v(1, 1, 1, 1, 1,    0, 0, 0, 0, 0));
    // E: first token after reset is an edge at time 0 (idx 23)
    vecs.push_back(v(0, 1, 1, 1, 1,    0, 1, 1, 1, 0));

    @(negedge clock);

    run(0, 6);

    run(7, 12);
    check("B err_kind", 64'(err_kind), 64'd1);
    check("B err_model_time", err_model_time, 64'd2000);
    check("B err_ref_time", err_ref_time, 64'd2500);
    check("B err_model_data", 64'(err_model_data), 64'd1);
    check("B err_ref_data", 64'(err_ref_data), 64'd1);

    run(13, 17);
    check("C err_kind", 64'(err_kind), 64'd3);
    check("C err_model_time", err_model_time, 64'd1000);
    check("C err_ref_time", err_ref_time, 64'd1000);
    check("C err_model_data", 64'(err_model_data), 64'd0);
    check("C err_ref_data", 64'(err_ref_data), 64'd1);

    run(18, 22);
    check("D err_kind", 64'(err_kind), 64'd0);
    check("D err_model_time", err_model_time, 64'd0);
    check("D err_ref_time", err_ref_time, 64'd0);
    run(23, 23);

    // Edge token stalls without a reference entry; time must not advance
    apply(v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 10; i++)
      apply(v(0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    apply(v(0, 1, 1, 1, 1, 0, 1, 1, 1, 0));

    // Saturation: preload mismatch counter just below the ceiling
    force dut.mismatch_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.mismatch_cnt;
    check("preload", 64'(mismatch_count), 64'hFFFF_FFFE);
    #1;
    apply(v(0, 1, 0, 1, 1, 1000, 1, 1, 1, 32'hFFFF_FFFF));
    apply(v(0, 1, 1, 1, 0, 2000, 1, 1, 1, 32'hFFFF_FFFF));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/timestamped_stream_checker.md
TIMESTAMPED_STREAM_CHECKER -- requirements
Module: timestamped_stream_checker

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 1, width of the compared signal.
REQ-002 SHALL have parameter PERIOD_PS, default 1000, simulated picoseconds advanced per model token.
REQ-003 SHALL have port clock, input, 1, sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous, active-high.
REQ-005 SHALL have ports model_valid (input, 1), model_ready (output, 1) and model_data (input, DATA_WIDTH): one model token per simulated cycle.
REQ-006 SHALL have ports ref_valid (input, 1), ref_ready (output, 1), ref_data (input, DATA_WIDTH) and ref_time (input, 64): timestamped reference transitions, time in ps.
REQ-007 SHALL have port error, output, 1, sticky mismatch flag.
REQ-008 SHALL have ports match_count and mismatch_count, output, 32 each, saturating counters.
REQ-009 SHALL have ports err_kind (output, 2), err_model_time (output, 64), err_ref_time (output, 64), err_model_data (output, DATA_WIDTH) and err_ref_data (output, DATA_WIDTH), holding first-mismatch details.

Function
REQ-010 SHALL keep model_time, 64-bit: the simulated time of the head model token; it starts at 0 and adds PERIOD_PS on each model fire, wrapping modulo 2^64.
REQ-011 SHALL keep prev_data and a first flag; edge = first OR model_data != prev_data.
REQ-012 On a model fire, SHALL update prev_data to model_data and clear first.
REQ-013 Edge token: model_ready = ref_ready = model_valid AND ref_valid; both streams fire together.
REQ-014 Edge fire: SHALL compare ref_time == model_time and ref_data == model_data. Both equal -> match, err_kind 0. Otherwise -> mismatch: err_kind 1 if only time differs, 2 if data differs.
REQ-015 Non-edge token with ref_valid AND ref_time <= model_time: SHALL set ref_ready=1 and model_ready=0, pop the reference entry and count a mismatch with err_kind 3 (unexpected reference transition).
REQ-016 Non-edge token with NOT ref_valid, or with ref_time > model_time: SHALL set model_ready=1 and ref_ready=0, consume the token and count nothing.
REQ-017 With model_valid low: model_ready=0 and ref_ready=0; no state changes.
REQ-018 Results SHALL be registered: counters, error and err_* update on the clock edge of the fire; they are visible the cycle after the handshake.
REQ-019 Counters SHALL saturate at 0xFFFFFFFF and never wrap.
REQ-020 err_* SHALL capture only the first mismatch after reset; later mismatches increment mismatch_count only.
REQ-021 error SHALL equal (mismatch_count != 0) and remain high until reset.
REQ-022 ready outputs SHALL be combinational from valid and data inputs and registered state, with no combinational dependence on the partner's ready.
REQ-023 At most one comparison SHALL occur per cycle; throughput is one token per cycle when ref entries are available for edges.

Reset
REQ-024 On reset: model_time=0, first=1, prev_data=0, counters=0, error=0, err_kind=0, all err_* fields=0.
REQ-025 During reset, model_ready=0 and ref_ready=0; nothing is consumed.
REQ-026 Reset asserted mid-operation SHALL discard all history; the next token after release is treated as first (edge) at time 0.

Verification
REQ-027 PERIOD_PS=1000; model tokens 0,0,1,1,0; ref entries (0,0),(2000,1),(4000,0) -> match_count=3, mismatch_count=0, error=0, all tokens consumed.
REQ-028 Same model stream; ref (0,0),(2500,1),(4000,0) -> mismatch_count=1, err_kind=1, err_model_time=2000, err_ref_time=2500, match_count=2.
REQ-029 Model 0,0,0; ref (0,0),(1000,1) -> second reference entry popped at model_time 1000, err_kind=3, err_ref_data=1, mismatch_count=1.
REQ-030 Edge token presented with ref_valid=0 for 10 cycles -> model_ready stays 0 and model_time unchanged; ref_valid raised -> fire in that same cycle.
REQ-031 Force mismatch_count to 0xFFFFFFFF via repeated mismatches, or preload it in the bench -> a further mismatch leaves it at 0xFFFFFFFF.
REQ-032 Reset pulse after 3 mismatches -> error=0, counters=0; the next token with data 1 is an edge compared at time 0.
